// File: rtl/cache_pkg.sv
// Shared definitions for the cache line transfer engine.
//   xfer_state_e : engine state encoding (IDLE, EVICT, REFILL, DONE)
//   SKID_DEPTH   : entries in the writeback skid buffer
//   clog2_min1   : ceil(log2(v)), never less than 1, for counter and index widths
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVICT  = 2'd1,
    REFILL = 2'd2,
    DONE   = 2'd3
  } xfer_state_e;

  localparam int unsigned SKID_DEPTH = 2;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/cache_wb_skid.sv
// Two-entry FIFO that holds RAM read data during an eviction until the bus
// accepts it.
//   clk, rst : clock, synchronous active-high reset (empties the buffer)
//   push/din : write one entry (caller guarantees there is room)
//   pop      : drop the head entry (caller guarantees it is non-empty)
//   dout     : head entry
//   count    : number of valid entries, 0..2
module cache_wb_skid
  import cache_pkg::*;
#(
  parameter int DATAWIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATAWIDTH-1:0] din,
  input  logic                 pop,
  output logic [DATAWIDTH-1:0] dout,
  output logic [1:0]           count
);

  logic [DATAWIDTH-1:0] mem [SKID_DEPTH];
  logic                 wr_ptr;
  logic                 rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/cache_line_xfer.sv
// Line-granular transfer engine between the cache data RAM and the memory bus.
// An accepted request optionally evicts the line (RAM reads streamed out on the
// wb_* channel) and then refills it (rf_* beats written into the RAM).
//   req_*    : controller request handshake; done pulses once per request
//   cm_*     : cache RAM ports (read byte address, write address/data/enable/byte selects)
//   wb_*     : writeback stream to the bus (valid/ready, last marks the final beat)
//   rf_*     : refill stream from the bus (valid/ready)
module cache_line_xfer
  import cache_pkg::*;
#(
  parameter  int DATAWIDTH   = 64,
  parameter  int CACHE_DEPTH = 2048,
  parameter  int LINE_BEATS  = 4,
  localparam int CSWIDTH     = DATAWIDTH / 8,
  localparam int ADDR_WID    = $clog2(CACHE_DEPTH),
  localparam int ADDR_LSB    = $clog2(CSWIDTH),
  localparam int BEAT_WID    = clog2_min1(LINE_BEATS),
  localparam int LINE_WID    = ADDR_WID - BEAT_WID
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_evict,
  input  logic [LINE_WID-1:0]          req_line,
  output logic                         done,
  output logic [ADDR_WID+ADDR_LSB-1:0] cm_raddr,
  input  logic [DATAWIDTH-1:0]         cm_rdata,
  output logic [ADDR_WID+ADDR_LSB-1:0] cm_waddr,
  output logic [DATAWIDTH-1:0]         cm_wdata,
  output logic                         cm_we,
  output logic [CSWIDTH-1:0]           cm_bsel,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [DATAWIDTH-1:0]         wb_data,
  output logic                         wb_last,
  input  logic                         rf_valid,
  output logic                         rf_ready,
  input  logic [DATAWIDTH-1:0]         rf_data
);

  localparam logic [BEAT_WID-1:0] LAST_BEAT = BEAT_WID'(LINE_BEATS - 1);

  xfer_state_e                  state_q, state_d;
  logic [LINE_WID-1:0]          line_q;
  logic [BEAT_WID-1:0]          rd_beat_q;
  logic                         rd_all_q;
  logic                         rd_pend_q;
  logic [BEAT_WID-1:0]          wb_beat_q;
  logic [BEAT_WID-1:0]          rf_beat_q;
  logic                         we_q;
  logic [ADDR_WID+ADDR_LSB-1:0] waddr_q;
  logic [DATAWIDTH-1:0]         wdata_q;

  logic [1:0]                   skid_cnt;
  logic [DATAWIDTH-1:0]         skid_dout;
  logic                         wb_fire;
  logic                         rf_fire;
  logic                         rd_issue;
  logic [2:0]                   slots_used;

  cache_wb_skid #(.DATAWIDTH(DATAWIDTH)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_pend_q),
    .din   (cm_rdata),
    .pop   (wb_fire),
    .dout  (skid_dout),
    .count (skid_cnt)
  );

  assign wb_valid = (state_q == EVICT) && (skid_cnt != 2'd0);
  assign wb_data  = skid_dout;
  assign wb_last  = wb_valid && (wb_beat_q == LAST_BEAT);
  assign wb_fire  = wb_valid && wb_ready;
  assign rf_fire  = (state_q == REFILL) && rf_valid;

  // A slot freed by this cycle's pop counts as available, which keeps one
  // beat per cycle flowing with wb_ready high while in-flight + buffered
  // still never exceeds the two skid entries.
  assign slots_used = 3'(skid_cnt) + 3'(rd_pend_q) - 3'(wb_fire);
  assign rd_issue   = (state_q == EVICT) && !rd_all_q && (slots_used < 3'd2);

  // The RAM samples this address at the edge; data appears on cm_rdata the
  // following cycle, when rd_pend_q pushes it into the skid buffer.
  assign cm_raddr = {line_q, rd_beat_q, {ADDR_LSB{1'b0}}};
  assign cm_waddr = waddr_q;
  assign cm_wdata = wdata_q;
  assign cm_we    = we_q;
  assign cm_bsel  = {CSWIDTH{we_q}};

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rf_ready  = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_evict ? EVICT : REFILL;
      end
      EVICT: begin
        if (wb_fire && (wb_beat_q == LAST_BEAT)) state_d = REFILL;
      end
      REFILL: begin
        rf_ready = 1'b1;
        if (rf_fire && (rf_beat_q == LAST_BEAT)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      line_q    <= '0;
      rd_beat_q <= '0;
      rd_all_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      wb_beat_q <= '0;
      rf_beat_q <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_issue;
      we_q      <= rf_fire;
      if (req_valid && req_ready) begin
        line_q    <= req_line;
        rd_beat_q <= '0;
        rd_all_q  <= 1'b0;
        wb_beat_q <= '0;
        rf_beat_q <= '0;
      end
      if (rd_issue) begin
        rd_beat_q <= rd_beat_q + BEAT_WID'(1);
        if (rd_beat_q == LAST_BEAT) rd_all_q <= 1'b1;
      end
      if (wb_fire) wb_beat_q <= wb_beat_q + BEAT_WID'(1);
      if (rf_fire) begin
        waddr_q   <= {line_q, rf_beat_q, {ADDR_LSB{1'b0}}};
        wdata_q   <= rf_data;
        rf_beat_q <= rf_beat_q + BEAT_WID'(1);
      end
    end
  end

endmodule
